// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: per-line consumer of the active sprite list.
// For each active entry it pops the sprite number, reads SCB3 (Y/sticky/size)
// and SCB2 (shrink) from fast VRAM, computes the shrunk sprite-relative row
// for the current raster line and issues one SCB1 tile fetch request.
//
// Ports:
//   CLK_24M, RESETP            clock, synchronous active-high reset
//   LINE_START, RASTERC        pass start pulse and raster line to process
//   ACT_VALID/NUM/LAST, ACT_ACK active-list read port (ACK is combinational pop)
//   ATTR_REQ/ADDR/VALID/DATA   fast-VRAM attribute read port
//   TILE_REQ/ADDR/LINE/READY   tile fetch request to the render path
//   SPR_COUNT, DONE            entries processed this line, pass finished
module sprite_line_fetch (
  input  logic        CLK_24M,
  input  logic        RESETP,
  input  logic        LINE_START,
  input  logic [8:0]  RASTERC,
  input  logic        ACT_VALID,
  input  logic [8:0]  ACT_NUM,
  input  logic        ACT_LAST,
  output logic        ACT_ACK,
  output logic        ATTR_REQ,
  output logic [15:0] ATTR_ADDR,
  input  logic        ATTR_VALID,
  input  logic [15:0] ATTR_DATA,
  output logic        TILE_REQ,
  output logic [15:0] TILE_ADDR,
  output logic [3:0]  TILE_LINE,
  input  logic        TILE_READY,
  output logic [6:0]  SPR_COUNT,
  output logic        DONE
);

  localparam int unsigned MAX_SPR = 96;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_RD3, S_RD2, S_CALC, S_ISSUE, S_DONE
  } state_t;

  state_t state, next_state;

  logic [8:0] line_r, num, y_r, py;
  logic       sticky_r;
  logic [5:0] size_r, psize;
  logic [7:0] shr_r, pshr;

  logic [8:0] eff_y, row, rows;
  logic [5:0] eff_size;
  logic [7:0] eff_shr;
  logic [4:0] tile;
  logic [3:0] tline;
  logic       skip;
  logic [8:0] attr_num;

  // State register
  always_ff @(posedge CLK_24M) begin
    if (RESETP) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next state and the combinational list pop
  always_comb begin
    next_state = state;
    ACT_ACK    = 1'b0;
    if (LINE_START) begin
      next_state = S_POP;
    end else begin
      case (state)
        S_IDLE: next_state = S_IDLE;
        S_POP: begin
          if (SPR_COUNT == 7'(MAX_SPR)) begin
            next_state = S_DONE;
          end else if (ACT_VALID) begin
            ACT_ACK    = 1'b1;
            next_state = ACT_LAST ? S_DONE : S_RD3;
          end
        end
        S_RD3:   if (ATTR_VALID) next_state = S_RD2;
        S_RD2:   if (ATTR_VALID) next_state = S_CALC;
        S_CALC:  next_state = skip ? S_POP : S_ISSUE;
        S_ISSUE: if (TILE_READY) next_state = S_POP;
        S_DONE:  next_state = S_DONE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Sticky sprites inherit the previous sprite's Y, size and shrink
  always_comb begin
    eff_y    = sticky_r ? py    : y_r;
    eff_size = sticky_r ? psize : size_r;
    eff_shr  = sticky_r ? pshr  : shr_r;
    row      = 9'(line_r + eff_y);
    rows     = 9'((17'(row) * 17'(9'(eff_shr) + 9'd1)) >> 8);
    tile     = rows[8:4];
    tline    = rows[3:0];
    // Sizes of 32 and above never clip on tile index
    skip     = (eff_size == 6'd0) || (!eff_size[5] && ({1'b0, tile} >= eff_size));
  end

  // Entry number driving the attribute address on the POP->RD3 transition
  assign attr_num = (state == S_POP) ? ACT_NUM : num;

  // Datapath and registered outputs
  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      line_r    <= '0;
      num       <= '0;
      y_r       <= '0;
      sticky_r  <= 1'b0;
      size_r    <= '0;
      shr_r     <= '0;
      py        <= '0;
      psize     <= '0;
      pshr      <= '0;
      SPR_COUNT <= '0;
      ATTR_REQ  <= 1'b0;
      ATTR_ADDR <= '0;
      TILE_REQ  <= 1'b0;
      TILE_ADDR <= '0;
      TILE_LINE <= '0;
      DONE      <= 1'b0;
    end else begin
      if (LINE_START) begin
        line_r    <= RASTERC;
        SPR_COUNT <= '0;
        py        <= '0;
        psize     <= '0;
        pshr      <= '0;
      end else begin
        case (state)
          S_POP: if (next_state == S_RD3) num <= ACT_NUM;
          S_RD3: begin
            if (ATTR_VALID) begin
              y_r      <= ATTR_DATA[15:7];
              sticky_r <= ATTR_DATA[6];
              size_r   <= ATTR_DATA[5:0];
            end
          end
          S_RD2: if (ATTR_VALID) shr_r <= ATTR_DATA[7:0];
          S_CALC: begin
            py        <= eff_y;
            psize     <= eff_size;
            pshr      <= eff_shr;
            TILE_ADDR <= 16'({num, tile, 1'b0});
            TILE_LINE <= tline;
            if (SPR_COUNT != 7'(MAX_SPR)) SPR_COUNT <= SPR_COUNT + 7'd1;
          end
          default: ;
        endcase
      end

      ATTR_REQ <= (next_state == S_RD3) || (next_state == S_RD2);
      if (next_state == S_RD3)      ATTR_ADDR <= 16'h8200 + 16'(attr_num);
      else if (next_state == S_RD2) ATTR_ADDR <= 16'h8000 + 16'(num);
      TILE_REQ <= (next_state == S_ISSUE);
      DONE     <= (next_state == S_DONE);
    end
  end

endmodule
